// File: rtl/param_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : param_commit_ctrl
// Purpose  : Assembles framed 16-bit host words into 32-bit writes to a
//            shadow parameter bank. On a commit command, it copies the dirty
//            shadow registers into the active bank on the next synchronised
//            sim_clk rising edge, so the datapath never sees a half-updated
//            parameter set.
// Revision : 1.0 - initial release
// ============================================================================
module param_commit_ctrl #(
  parameter int                NREG       = 8,
  parameter logic [NREG*32-1:0] RESET_VALS = {NREG{32'h0000_0000}},
  parameter int                TIMEOUT    = 1024
) (
  input  logic                 clk,
  input  logic                 reset_global,
  input  logic                 sim_clk,
  input  logic                 word_valid,
  input  logic [15:0]          word_data,
  output logic [NREG*32-1:0]   params_out,
  output logic                 commit_pulse,
  output logic                 commit_pending,
  output logic [1:0]           frame_state,
  output logic [7:0]           err_cnt,
  output logic [15:0]          commit_cnt
);

  localparam int             TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  localparam logic [3:0] OP_WRITE  = 4'hA;
  localparam logic [3:0] OP_COMMIT = 4'hC;
  localparam logic [3:0] OP_RELOAD = 4'hD;

  typedef enum logic [1:0] {
    ST_HDR = 2'd0,
    ST_HI  = 2'd1,
    ST_LO  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         addr_q, addr_d;
  logic [15:0]        hi_q, hi_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic               err_inc;
  logic               wr_en;
  logic               reload;
  logic               commit_hdr;
  logic               addr_ok;

  logic               sync1_q, sync2_q, sync3_q;
  logic               edge_flag;
  logic               do_commit;

  logic               pending_q;
  logic               pulse_q;
  logic [7:0]         err_q;
  logic [15:0]        ccnt_q;

  // Address range check for the data phase; addresses at or above NREG drop.
  assign addr_ok = ({24'd0, addr_q} < 32'(NREG));

  // The sync3 flop is the edge register: a rise is seen when sync2 is high
  // and its delayed copy is still low.
  assign edge_flag = sync2_q & ~sync3_q;
  // The commit reads the registered pending flag, so a commit header arriving
  // on the edge cycle waits for the next edge.
  assign do_commit = edge_flag & pending_q;

  // Frame FSM state and frame-assembly registers.
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      state_q <= ST_HDR;
      addr_q  <= 8'd0;
      hi_q    <= 16'd0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state decode: header parsing, data phases and inter-word timeout.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    hi_d       = hi_q;
    tmo_d      = '0;
    err_inc    = 1'b0;
    wr_en      = 1'b0;
    reload     = 1'b0;
    commit_hdr = 1'b0;
    case (state_q)
      ST_HDR: begin
        if (word_valid) begin
          case (word_data[15:12])
            OP_WRITE: begin
              addr_d  = word_data[7:0];
              state_d = ST_HI;
            end
            OP_COMMIT: commit_hdr = 1'b1;
            OP_RELOAD: reload     = 1'b1;
            default:   err_inc    = 1'b1;
          endcase
        end
      end
      ST_HI, ST_LO: begin
        if (word_valid) begin
          if (state_q == ST_HI) begin
            hi_d    = word_data;
            state_d = ST_LO;
          end else begin
            if (addr_ok) begin
              wr_en = 1'b1;
            end else begin
              err_inc = 1'b1;
            end
            state_d = ST_HDR;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Host stalled mid-frame: drop the partial frame.
          err_inc = 1'b1;
          state_d = ST_HDR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  // Two-flop synchroniser for sim_clk plus the edge-detect register.
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sim_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Commit handshake, commit pulse and the status counters.
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      pending_q <= 1'b0;
      pulse_q   <= 1'b0;
      err_q     <= 8'd0;
      ccnt_q    <= 16'd0;
    end else begin
      if (do_commit) begin
        pending_q <= 1'b0;
      end else if (commit_hdr) begin
        pending_q <= 1'b1;
      end
      pulse_q <= do_commit;
      if (do_commit) begin
        ccnt_q <= ccnt_q + 16'd1;
      end
      if (err_inc && (err_q != 8'hFF)) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  // Per-register shadow, active and dirty storage.
  for (genvar k = 0; k < NREG; k++) begin : g_reg
    logic [31:0] shadow_q;
    logic [31:0] active_q;
    logic        dirty_q;
    logic        wr_hit;

    assign wr_hit = wr_en & (addr_q == 8'(k));

    // Shadow takes writes or a reload; active copies shadow only on commit.
    // A write on the commit edge commits the old shadow and stays dirty.
    always_ff @(posedge clk or posedge reset_global) begin
      if (reset_global) begin
        shadow_q <= RESET_VALS[32*k +: 32];
        active_q <= RESET_VALS[32*k +: 32];
        dirty_q  <= 1'b0;
      end else begin
        if (reload) begin
          shadow_q <= RESET_VALS[32*k +: 32];
        end else if (wr_hit) begin
          shadow_q <= {hi_q, word_data};
        end
        if (do_commit && dirty_q) begin
          active_q <= shadow_q;
        end
        if (reload || wr_hit) begin
          dirty_q <= 1'b1;
        end else if (do_commit) begin
          dirty_q <= 1'b0;
        end
      end
    end

    assign params_out[32*k +: 32] = active_q;
  end

  assign commit_pulse   = pulse_q;
  assign commit_pending = pending_q;
  assign frame_state    = state_q;
  assign err_cnt        = err_q;
  assign commit_cnt     = ccnt_q;

endmodule
`default_nettype wire

// File: tb/tb_param_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_commit_ctrl
// Purpose  : Directed self-checking bench for param_commit_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_commit_ctrl;

  localparam int NREG    = 8;
  localparam int TIMEOUT = 32;
  localparam logic [NREG*32-1:0] RV = {
    32'hA5A5_0007, 32'hA5A5_0006, 32'hA5A5_0005, 32'hA5A5_0004,
    32'hA5A5_0003, 32'h42A0_0000, 32'hA5A5_0001, 32'hA5A5_0000
  };

  logic                 clk;
  logic                 reset_global;
  logic                 sim_clk;
  logic                 word_valid;
  logic [15:0]          word_data;
  logic [NREG*32-1:0]   params_out;
  logic                 commit_pulse;
  logic                 commit_pending;
  logic [1:0]           frame_state;
  logic [7:0]           err_cnt;
  logic [15:0]          commit_cnt;

  int          n_cmp;
  int          n_err;
  int          pulse_cnt;
  int          p0;
  int          lat;
  logic [31:0] exp_regs [NREG];

  param_commit_ctrl #(
    .NREG       (NREG),
    .RESET_VALS (RV),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset_global   (reset_global),
    .sim_clk        (sim_clk),
    .word_valid     (word_valid),
    .word_data      (word_data),
    .params_out     (params_out),
    .commit_pulse   (commit_pulse),
    .commit_pending (commit_pending),
    .frame_state    (frame_state),
    .err_cnt        (err_cnt),
    .commit_cnt     (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts clk cycles during which commit_pulse is high.
  always @(negedge clk) begin
    if (commit_pulse === 1'b1) pulse_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] w);
    word_valid = 1'b1;
    word_data  = w;
    @(posedge clk); #1;
    word_valid = 1'b0;
    word_data  = 16'h0000;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Raise sim_clk, watch a bounded window for commit_pulse, then lower it.
  task automatic sim_pulse(output int l);
    l = -1;
    sim_clk = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (commit_pulse && l < 0) l = i;
    end
    sim_clk = 1'b0;
    idle(5);
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < NREG; k++) begin
      check($sformatf("%s_reg%0d", tag, k), 64'(params_out[32*k +: 32]), 64'(exp_regs[k]));
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; pulse_cnt = 0;
    reset_global = 1'b1;
    sim_clk = 1'b0;
    word_valid = 1'b0;
    word_data = 16'h0000;
    for (int k = 0; k < NREG; k++) exp_regs[k] = RV[32*k +: 32];
    idle(3);
    reset_global = 1'b0;
    idle(2);

    // Reset state
    check_regs("rst");
    check("rst_reg2", 64'(params_out[95:64]), 64'h42A0_0000);
    check("rst_state", 64'(frame_state), 64'd0);
    check("rst_err", 64'(err_cnt), 64'd0);
    check("rst_ccnt", 64'(commit_cnt), 64'd0);
    check("rst_pend", 64'(commit_pending), 64'd0);
    check("rst_pulse", 64'(pulse_cnt), 64'd0);

    // Basic write + commit
    send(16'hA003); send(16'h3E71); send(16'h4120); send(16'hC000);
    check("t2_pend", 64'(commit_pending), 64'd1);
    check_regs("t2_pre");
    p0 = pulse_cnt;
    sim_pulse(lat);
    check("t2_lat_ok", 64'(lat >= 3 && lat <= 4), 64'd1);
    check("t2_pulses", 64'(pulse_cnt - p0), 64'd1);
    exp_regs[3] = 32'h3E71_4120;
    check_regs("t2");
    check("t2_ccnt", 64'(commit_cnt), 64'd1);
    check("t2_pend0", 64'(commit_pending), 64'd0);

    // Write without commit across several edges, then commit
    send(16'hA001); send(16'h0000); send(16'h0001);
    p0 = pulse_cnt;
    repeat (5) sim_pulse(lat);
    check("t3_nopulse", 64'(pulse_cnt - p0), 64'd0);
    check("t3_reg1_hold", 64'(params_out[63:32]), 64'hA5A5_0001);
    check("t3_ccnt_hold", 64'(commit_cnt), 64'd1);
    send(16'hC000);
    sim_pulse(lat);
    exp_regs[1] = 32'h0000_0001;
    check_regs("t3");
    check("t3_ccnt", 64'(commit_cnt), 64'd2);

    // Bad opcode and out-of-range address
    send(16'h5000);
    check("t4_err1", 64'(err_cnt), 64'd1);
    check("t4_state_hdr", 64'(frame_state), 64'd0);
    send(16'hA0FF); send(16'h1111); send(16'h2222);
    check("t4_err2", 64'(err_cnt), 64'd2);
    check("t4_state", 64'(frame_state), 64'd0);
    send(16'hC000);
    sim_pulse(lat);
    check_regs("t4");
    check("t4_ccnt", 64'(commit_cnt), 64'd3);

    // Inter-word timeout
    send(16'hA002); send(16'h1234);
    check("t5_state_lo", 64'(frame_state), 64'd2);
    idle(TIMEOUT - 1);
    check("t5_state_still", 64'(frame_state), 64'd2);
    check("t5_err_still", 64'(err_cnt), 64'd2);
    idle(1);
    check("t5_state_hdr", 64'(frame_state), 64'd0);
    check("t5_err", 64'(err_cnt), 64'd3);
    send(16'hA002); send(16'hABCD); send(16'h0123); send(16'hC000);
    sim_pulse(lat);
    exp_regs[2] = 32'hABCD_0123;
    check_regs("t5");
    check("t5_ccnt", 64'(commit_cnt), 64'd4);

    // Write landing on the commit edge; write while pending joins the commit
    send(16'hC000);
    send(16'hA005); send(16'h7777); send(16'h8888);
    send(16'hA004); send(16'h5555);
    p0 = pulse_cnt;
    sim_clk = 1'b1;
    idle(2);
    send(16'h6666);
    check("t6_pulse", 64'(commit_pulse), 64'd1);
    exp_regs[5] = 32'h7777_8888;
    check_regs("t6a");
    check("t6_ccnt", 64'(commit_cnt), 64'd5);
    check("t6_pend0", 64'(commit_pending), 64'd0);
    idle(4);
    sim_clk = 1'b0;
    idle(5);
    check("t6_pulses", 64'(pulse_cnt - p0), 64'd1);
    send(16'hC000);
    sim_pulse(lat);
    exp_regs[4] = 32'h5555_6666;
    check_regs("t6b");
    check("t6_ccnt2", 64'(commit_cnt), 64'd6);

    // Reset while a commit is pending
    send(16'hA006); send(16'hDEAD); send(16'hBEEF); send(16'hC000);
    check("t7_pend", 64'(commit_pending), 64'd1);
    p0 = pulse_cnt;
    reset_global = 1'b1;
    idle(3);
    reset_global = 1'b0;
    idle(2);
    sim_pulse(lat);
    for (int k = 0; k < NREG; k++) exp_regs[k] = RV[32*k +: 32];
    check("t7_nopulse", 64'(pulse_cnt - p0), 64'd0);
    check_regs("t7");
    check("t7_pend0", 64'(commit_pending), 64'd0);
    check("t7_ccnt", 64'(commit_cnt), 64'd0);
    check("t7_err", 64'(err_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
